ct_had_ddc_dp: RTL and testbench

//  Datapath for HAD direct-download (DDC): sits directly downstream of the DDC control FSM.

---
 rtl/ct_had_ddc_pkg.sv | 21 ++
 rtl/ct_had_ddc_data_buf.sv | 44 ++++
 rtl/ct_had_ddc_dp.sv | 103 ++++++++++
 tb/tb_ct_had_ddc_dp.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ct_had_ddc_pkg.sv
// Shared definitions for the HAD direct-download (DDC) control FSM and datapath.
package ct_had_ddc_pkg;

    // Instructions fed to the core IR while a download is in progress.
    localparam logic [31:0] INST_MV_A0 = 32'h0005_0513;  // mv a0, a0 (WBBR -> a0)
    localparam logic [31:0] INST_MV_A1 = 32'h0005_8593;  // mv a1, a1 (WBBR -> a1)
    localparam logic [31:0] INST_SW    = 32'h00B5_2023;  // sw a1, 0(a0)

    // DDC control FSM state encodings, shared with the ctrl block.
    typedef enum logic [2:0] {
        DDC_IDLE     = 3'd0,
        DDC_ADDR_WT  = 3'd1,
        DDC_ADDR_LD  = 3'd2,
        DDC_DATA_WT  = 3'd3,
        DDC_DATA_LD  = 3'd4,
        DDC_STW_WT   = 3'd5,
        DDC_STW_LD   = 3'd6,
        DDC_ADDR_GEN = 3'd7
    } ddc_state_e;

endpackage

// File: rtl/ct_had_ddc_data_buf.sv
// DDATA holding register with valid and sticky overrun tracking.
module ct_had_ddc_data_buf #(
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          capture,
    input  logic          consume,
    input  logic [DW-1:0] dr_value,
    output logic [DW-1:0] ddata,
    output logic          data_vld,
    output logic          overrun
);

    // Capture JTAG data, track whether it has been consumed, flag overwrites.
    // A capture coinciding with a consume is a clean hand-off: the old word
    // leaves through the load mux this cycle, so it is not an overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            ddata    <= '0;
            data_vld <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (capture) begin
                ddata <= dr_value;
            end
            if (!en) begin
                data_vld <= 1'b0;
                overrun  <= 1'b0;
            end else begin
                if (capture) begin
                    data_vld <= 1'b1;
                end else if (consume) begin
                    data_vld <= 1'b0;
                end
                if (capture && data_vld && !consume) begin
                    overrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ct_had_ddc_dp.sv
// HAD direct-download datapath: JTAG capture, IR/WBBR load mux,
// download address generation and word counting.
module ct_had_ddc_dp
    import ct_had_ddc_pkg::*;
#(
    parameter int AW       = 64,
    parameter int DW       = 64,
    parameter int ADDR_INC = 4,
    parameter int CNT_W    = 16
) (
    input  logic             cpuclk,
    input  logic             cpurst,
    input  logic             regs_xx_ddc_en,
    input  logic             x_sm_xx_update_dr_en,
    input  logic             ir_xx_daddr_reg_sel,
    input  logic             ir_xx_ddata_reg_sel,
    input  logic [DW-1:0]    x_sm_xx_dr_value,
    input  logic             ddc_ctrl_dp_addr_sel,
    input  logic             ddc_ctrl_dp_data_sel,
    input  logic             ddc_ctrl_dp_addr_gen,
    input  logic             ddc_xx_update_ir,
    output logic [31:0]      ddc_dp_ir_value,
    output logic [AW-1:0]    ddc_dp_wbbr_value,
    output logic [AW-1:0]    ddc_dp_daddr,
    output logic [CNT_W-1:0] ddc_dp_word_cnt,
    output logic             ddc_dp_overrun
);

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [AW-1:0]    daddr;
    logic [CNT_W-1:0] word_cnt;
    logic [DW-1:0]    ddata;
    logic             data_vld;
    logic             overrun;
    logic             daddr_cap;
    logic             ddata_cap;
    logic             stw_sel;

    assign daddr_cap = x_sm_xx_update_dr_en & ir_xx_daddr_reg_sel;
    assign ddata_cap = x_sm_xx_update_dr_en & ir_xx_ddata_reg_sel;
    assign stw_sel   = ddc_xx_update_ir & ~ddc_ctrl_dp_addr_sel & ~ddc_ctrl_dp_data_sel;

    ct_had_ddc_data_buf #(
        .DW (DW)
    ) u_data_buf (
        .clk      (cpuclk),
        .rst      (cpurst),
        .en       (regs_xx_ddc_en),
        .capture  (ddata_cap),
        .consume  (ddc_ctrl_dp_data_sel),
        .dr_value (x_sm_xx_dr_value),
        .ddata    (ddata),
        .data_vld (data_vld),
        .overrun  (overrun)
    );

    // Download address: a JTAG write overrides the auto-increment.
    always_ff @(posedge cpuclk) begin
        if (cpurst) begin
            daddr <= '0;
        end else if (daddr_cap) begin
            daddr <= x_sm_xx_dr_value[AW-1:0];
        end else if (ddc_ctrl_dp_addr_gen) begin
            daddr <= daddr + AW'(ADDR_INC);
        end
    end

    // Stores-completed counter, cleared whenever DDC mode is off.
    always_ff @(posedge cpuclk) begin
        if (cpurst) begin
            word_cnt <= '0;
        end else if (!regs_xx_ddc_en) begin
            word_cnt <= '0;
        end else if (ddc_ctrl_dp_addr_gen) begin
            word_cnt <= sat_inc(word_cnt);
        end
    end

    // Load mux: same-cycle instruction/WBBR values for the FSM strobes.
    always_comb begin
        ddc_dp_ir_value   = '0;
        ddc_dp_wbbr_value = '0;
        if (ddc_ctrl_dp_addr_sel) begin
            ddc_dp_ir_value   = INST_MV_A0;
            ddc_dp_wbbr_value = daddr;
        end else if (ddc_ctrl_dp_data_sel) begin
            ddc_dp_ir_value   = INST_MV_A1;
            ddc_dp_wbbr_value = AW'(ddata);
        end else if (stw_sel) begin
            ddc_dp_ir_value   = INST_SW;
            ddc_dp_wbbr_value = '0;
        end
    end

    assign ddc_dp_daddr    = daddr;
    assign ddc_dp_word_cnt = word_cnt;
    assign ddc_dp_overrun  = overrun;

endmodule

// File: tb/tb_ct_had_ddc_dp.sv
// Directed-vector bench for the HAD DDC datapath.
module tb_ct_had_ddc_dp;

    localparam int AW    = 64;
    localparam int DW    = 64;
    localparam int CNT_W = 16;

    localparam logic [31:0] IR_A0 = 32'h0005_0513;
    localparam logic [31:0] IR_A1 = 32'h0005_8593;
    localparam logic [31:0] IR_SW = 32'h00B5_2023;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             update_dr;
    logic             daddr_reg_sel;
    logic             ddata_reg_sel;
    logic [DW-1:0]    dr_value;
    logic             addr_sel;
    logic             data_sel;
    logic             addr_gen;
    logic             update_ir;
    logic [31:0]      ir_value;
    logic [AW-1:0]    wbbr_value;
    logic [AW-1:0]    daddr;
    logic [CNT_W-1:0] word_cnt;
    logic             overrun;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    ct_had_ddc_dp #(
        .AW       (AW),
        .DW       (DW),
        .ADDR_INC (4),
        .CNT_W    (CNT_W)
    ) dut (
        .cpuclk               (clk),
        .cpurst               (rst),
        .regs_xx_ddc_en       (en),
        .x_sm_xx_update_dr_en (update_dr),
        .ir_xx_daddr_reg_sel  (daddr_reg_sel),
        .ir_xx_ddata_reg_sel  (ddata_reg_sel),
        .x_sm_xx_dr_value     (dr_value),
        .ddc_ctrl_dp_addr_sel (addr_sel),
        .ddc_ctrl_dp_data_sel (data_sel),
        .ddc_ctrl_dp_addr_gen (addr_gen),
        .ddc_xx_update_ir     (update_ir),
        .ddc_dp_ir_value      (ir_value),
        .ddc_dp_wbbr_value    (wbbr_value),
        .ddc_dp_daddr         (daddr),
        .ddc_dp_word_cnt      (word_cnt),
        .ddc_dp_overrun       (overrun)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        update_dr     = 1'b0;
        daddr_reg_sel = 1'b0;
        ddata_reg_sel = 1'b0;
        dr_value      = '0;
        addr_sel      = 1'b0;
        data_sel      = 1'b0;
        addr_gen      = 1'b0;
        update_ir     = 1'b0;
    endtask

    task automatic cap_daddr(input logic [DW-1:0] v);
        update_dr     = 1'b1;
        daddr_reg_sel = 1'b1;
        ddata_reg_sel = 1'b0;
        dr_value      = v;
    endtask

    task automatic cap_ddata(input logic [DW-1:0] v);
        update_dr     = 1'b1;
        daddr_reg_sel = 1'b0;
        ddata_reg_sel = 1'b1;
        dr_value      = v;
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        idle_inputs();
        step();
        step();
        rst = 1'b0;

        // Reset state
        check("rst_daddr", daddr, 64'h0);
        check("rst_word_cnt", {48'h0, word_cnt}, 64'h0);
        check("rst_overrun", {63'h0, overrun}, 64'h0);
        check("rst_ir", {32'h0, ir_value}, 64'h0);
        check("rst_wbbr", wbbr_value, 64'h0);

        // 1: DADDR capture then addr_sel
        en = 1'b1;
        cap_daddr(64'h8000_0000);
        step();
        idle_inputs();
        addr_sel = 1'b1;
        #1;
        check("t1_ir", {32'h0, ir_value}, {32'h0, IR_A0});
        check("t1_wbbr", wbbr_value, 64'h8000_0000);
        check("t1_daddr", daddr, 64'h8000_0000);
        step();
        idle_inputs();

        // 2: DDATA capture then data_sel, then a store strobe
        cap_ddata(64'h1234_5678);
        step();
        idle_inputs();
        check("t2_vld_set", {63'h0, dut.u_data_buf.data_vld}, 64'h1);
        data_sel = 1'b1;
        #1;
        check("t2_ir", {32'h0, ir_value}, {32'h0, IR_A1});
        check("t2_wbbr", wbbr_value, 64'h1234_5678);
        step();
        idle_inputs();
        check("t2_vld_clr", {63'h0, dut.u_data_buf.data_vld}, 64'h0);
        update_ir = 1'b1;
        #1;
        check("t2_stw_ir", {32'h0, ir_value}, {32'h0, IR_SW});
        check("t2_stw_wbbr", wbbr_value, 64'h0);
        addr_sel = 1'b1;
        data_sel = 1'b1;
        #1;
        check("prio_ir", {32'h0, ir_value}, {32'h0, IR_A0});
        check("prio_wbbr", wbbr_value, 64'h8000_0000);
        step();
        idle_inputs();

        // 3: address wrap and counter saturation
        cap_daddr(64'hFFFF_FFFF_FFFF_FFFC);
        step();
        idle_inputs();
        addr_gen = 1'b1;
        step();
        idle_inputs();
        check("t3_wrap_daddr", daddr, 64'h0);
        check("t3_cnt_one", {48'h0, word_cnt}, 64'h1);
        addr_gen = 1'b1;
        repeat (65534) step();
        check("t3_cnt_full", {48'h0, word_cnt}, 64'hFFFF);
        check("t3_daddr_run", daddr, 64'h3_FFF8);
        step();
        idle_inputs();
        check("t3_cnt_sat", {48'h0, word_cnt}, 64'hFFFF);
        check("t3_daddr_run2", daddr, 64'h3_FFFC);

        // 4a: capture coincident with consume is a clean hand-off
        cap_ddata(64'hC);
        step();
        data_sel = 1'b1;
        cap_ddata(64'hD);
        #1;
        check("t4_handoff_wbbr", wbbr_value, 64'hC);
        step();
        idle_inputs();
        check("t4_handoff_ovr", {63'h0, overrun}, 64'h0);
        check("t4_handoff_vld", {63'h0, dut.u_data_buf.data_vld}, 64'h1);
        data_sel = 1'b1;
        #1;
        check("t4_handoff_new", wbbr_value, 64'hD);
        step();
        idle_inputs();

        // 4b: two captures without consume
        cap_ddata(64'hA);
        step();
        cap_ddata(64'hB);
        step();
        idle_inputs();
        check("t4_overrun", {63'h0, overrun}, 64'h1);
        data_sel = 1'b1;
        #1;
        check("t4_ovr_wbbr", wbbr_value, 64'hB);
        step();
        idle_inputs();
        check("t4_ovr_sticky", {63'h0, overrun}, 64'h1);

        // 5: DADDR capture beats addr_gen; enable drop
        cap_daddr(64'h40);
        step();
        cap_daddr(64'h100);
        addr_gen = 1'b1;
        step();
        idle_inputs();
        check("t5_cap_wins", daddr, 64'h100);
        en = 1'b0;
        cap_ddata(64'h55);
        step();
        idle_inputs();
        check("t5_dis_cnt", {48'h0, word_cnt}, 64'h0);
        check("t5_dis_ovr", {63'h0, overrun}, 64'h0);
        check("t5_dis_daddr", daddr, 64'h100);
        en = 1'b1;
        data_sel = 1'b1;
        #1;
        check("t5_dis_capture", wbbr_value, 64'h55);
        step();
        idle_inputs();
        cap_daddr(64'h200);
        addr_gen = 1'b1;
        step();
        idle_inputs();
        check("t5_cnt_inc", {48'h0, word_cnt}, 64'h1);
        check("t5_daddr2", daddr, 64'h200);

        // 6: mid-operation reset with strobes in flight
        cap_ddata(64'h77);
        step();
        idle_inputs();
        rst = 1'b1;
        addr_gen = 1'b1;
        cap_daddr(64'h999);
        step();
        rst = 1'b0;
        idle_inputs();
        check("t6_daddr", daddr, 64'h0);
        check("t6_cnt", {48'h0, word_cnt}, 64'h0);
        check("t6_ovr", {63'h0, overrun}, 64'h0);
        check("t6_vld", {63'h0, dut.u_data_buf.data_vld}, 64'h0);
        check("t6_ir_idle", {32'h0, ir_value}, 64'h0);
        data_sel = 1'b1;
        #1;
        check("t6_wbbr", wbbr_value, 64'h0);
        check("t6_ir", {32'h0, ir_value}, {32'h0, IR_A1});
        step();
        idle_inputs();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
